// File: rtl/fir_in_sample_loader.sv
// ============================================================================
// fir_in_sample_loader : packs one Avalon-ST packet of samples into 64-bit
// words and writes them sequentially into the FIR input RAM (port s2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module fir_in_sample_loader #(
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int SAMPLE_W = 16,
  parameter int LANES    = 4,
  localparam int WORD_W  = SAMPLE_W * LANES,
  localparam int BE_W    = WORD_W / 8,
  localparam int WC_W    = $clog2(DEPTH + 1),
  localparam int SC_W    = $clog2(DEPTH * LANES + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                arm,
  input  logic [SAMPLE_W-1:0] snk_data,
  input  logic                snk_valid,
  input  logic                snk_startofpacket,
  input  logic                snk_endofpacket,
  output logic                snk_ready,
  output logic [ADDR_W-1:0]   address2,
  output logic                chipselect2,
  output logic                write2,
  output logic [BE_W-1:0]     byteenable2,
  output logic [WORD_W-1:0]   writedata2,
  output logic                clken2,
  output logic                done,
  output logic                full,
  output logic                sop_err,
  output logic [WC_W-1:0]     word_count,
  output logic [SC_W-1:0]     sample_count
);

  localparam int LANE_W     = $clog2(LANES);
  localparam int LANE_BYTES = SAMPLE_W / 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_FILL  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic                accept, store, flush, last_word, clear;
  logic [LANE_W-1:0]   lane;
  logic [WORD_W-1:0]   pack, word_nxt;
  logic [BE_W-1:0]     be_nxt;

  assign snk_ready = (state == S_ARMED) || (state == S_FILL) || (state == S_DRAIN);
  assign accept    = snk_valid & snk_ready;
  assign store     = accept & (((state == S_ARMED) & snk_startofpacket) | (state == S_FILL));
  assign lane      = (state == S_ARMED) ? '0 : sample_count[LANE_W-1:0];
  assign last_word = (word_count == WC_W'(DEPTH - 1));
  assign flush     = store & ((lane == LANE_W'(LANES - 1)) | snk_endofpacket);
  assign clear     = arm & ((state == S_IDLE) | (state == S_DONE));
  assign clken2    = 1'b1;
  assign done      = (state == S_DONE);

  // Lanes above the current one are still zero in pack, so a partial word
  // naturally flushes with its unfilled lanes cleared.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign word_nxt[l*SAMPLE_W +: SAMPLE_W] =
        (LANE_W'(l) == lane) ? snk_data : pack[l*SAMPLE_W +: SAMPLE_W];
    assign be_nxt[l*LANE_BYTES +: LANE_BYTES] = {LANE_BYTES{LANE_W'(l) <= lane}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (arm) state_nxt = S_ARMED;
      S_ARMED, S_FILL: begin
        if (store) begin
          if (snk_endofpacket)       state_nxt = S_DONE;
          else if (flush & last_word) state_nxt = S_DRAIN;
          else                        state_nxt = S_FILL;
        end
      end
      S_DRAIN: if (accept & snk_endofpacket) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address2     <= '0;
      chipselect2  <= 1'b0;
      write2       <= 1'b0;
      byteenable2  <= '0;
      writedata2   <= '0;
      full         <= 1'b0;
      sop_err      <= 1'b0;
      word_count   <= '0;
      sample_count <= '0;
      pack         <= '0;
    end else begin
      chipselect2 <= flush;
      write2      <= flush;
      if (clear) begin
        full         <= 1'b0;
        sop_err      <= 1'b0;
        word_count   <= '0;
        sample_count <= '0;
        pack         <= '0;
      end else begin
        if (store) begin
          sample_count <= sample_count + 1'b1;
          pack         <= flush ? '0 : word_nxt;
          if ((state == S_FILL) && snk_startofpacket) sop_err <= 1'b1;
        end
        if (flush) begin
          address2    <= word_count[ADDR_W-1:0];
          writedata2  <= word_nxt;
          byteenable2 <= be_nxt;
          if (word_count != WC_W'(DEPTH)) word_count <= word_count + 1'b1;
          if (last_word) full <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_in_sample_loader.sv
// ============================================================================
// tb_fir_in_sample_loader : randomized scoreboard bench for the sample loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fir_in_sample_loader;

  localparam int DEPTH = 1024;
  localparam int LANES = 4;
  localparam int CAP   = DEPTH * LANES;

  logic        clk = 1'b0;
  logic        reset_n, arm, snk_valid, sop, eop;
  logic [15:0] snk_data;
  logic        snk_ready, chipselect2, write2, clken2, done, full, sop_err;
  logic [9:0]  address2;
  logic [7:0]  byteenable2;
  logic [63:0] writedata2;
  logic [10:0] word_count;
  logic [12:0] sample_count;

  typedef struct { logic [15:0] d; bit sop; bit eop; } smp_t;
  typedef struct { logic [9:0] addr; logic [63:0] data; logic [7:0] be; } wr_t;

  smp_t        frame[$];
  wr_t         exp_q[$];
  logic [63:0] mem [0:DEPTH-1];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  fir_in_sample_loader dut (
    .clk(clk), .reset_n(reset_n), .arm(arm),
    .snk_data(snk_data), .snk_valid(snk_valid),
    .snk_startofpacket(sop), .snk_endofpacket(eop), .snk_ready(snk_ready),
    .address2(address2), .chipselect2(chipselect2), .write2(write2),
    .byteenable2(byteenable2), .writedata2(writedata2), .clken2(clken2),
    .done(done), .full(full), .sop_err(sop_err),
    .word_count(word_count), .sample_count(sample_count)
  );

  // Simple RAM model standing in for the s2 side of the sample RAM.
  always @(posedge clk)
    if (chipselect2 && write2 && clken2)
      for (int b = 0; b < 8; b++)
        if (byteenable2[b]) mem[address2][8*b +: 8] <= writedata2[8*b +: 8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the head of the scoreboard.
  always @(negedge clk) begin
    wr_t w;
    if (reset_n && (write2 || chipselect2)) begin
      chk("cs_matches_write", {63'd0, chipselect2}, {63'd0, write2});
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: addr=%0h data=%0h be=%0h", address2, writedata2, byteenable2);
      end else begin
        w = exp_q.pop_front();
        chk("wr_addr", {54'd0, address2}, {54'd0, w.addr});
        chk("wr_data", writedata2, w.data);
        chk("wr_be", {56'd0, byteenable2}, {56'd0, w.be});
      end
    end
  end

  task automatic add(input logic [15:0] d, input bit s, input bit e);
    smp_t x;
    x.d = d; x.sop = s; x.eop = e;
    frame.push_back(x);
  endtask

  task automatic do_arm();
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    chk("arm_clears_status", {done, full, sop_err, word_count, sample_count}, '0);
  endtask

  task automatic send(input logic [15:0] d, input bit s, input bit e, input bit a, input int maxgap);
    int n;
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    repeat (gap) begin @(negedge clk); snk_valid = 1'b0; arm = 1'b0; end
    @(negedge clk);
    snk_data = d; sop = s; eop = e; snk_valid = 1'b1; arm = a;
    n = 0;
    while (!snk_ready && n < 100) begin @(negedge clk); arm = 1'b0; n++; end
    if (!snk_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: snk_ready=%0b required=1", snk_ready);
    end
    @(posedge clk);
  endtask

  // Reference model: collect the samples the frame should store, then cut them
  // into words of LANES samples; status follows from the stored count.
  task automatic run_frame(input bit complete, input int maxgap, input int arm_at);
    logic [15:0] st[$];
    bit          started, serr;
    int          nw, n;
    wr_t         w;
    started = 0; serr = 0;
    foreach (frame[i]) begin
      if (!started) begin
        if (!frame[i].sop) continue;
        started = 1;
        st.push_back(frame[i].d);
      end else if (st.size() < CAP) begin
        if (frame[i].sop) serr = 1;
        st.push_back(frame[i].d);
      end
      if (frame[i].eop) break;
    end
    nw = complete ? (st.size() + LANES - 1) / LANES : st.size() / LANES;
    for (int k = 0; k < nw; k++) begin
      w.addr = 10'(k); w.data = '0; w.be = '0;
      for (int l = 0; l < LANES; l++)
        if (k * LANES + l < st.size()) begin
          w.data[16*l +: 16] = st[k * LANES + l];
          w.be[2*l +: 2]     = 2'b11;
        end
      exp_q.push_back(w);
    end
    do_arm();
    foreach (frame[i]) send(frame[i].d, frame[i].sop, frame[i].eop, i == arm_at, maxgap);
    @(negedge clk);
    snk_valid = 1'b0; arm = 1'b0; sop = 1'b0; eop = 1'b0;
    if (complete) begin
      n = 0;
      while (!done && n < 200) begin @(negedge clk); n++; end
      chk("done", {63'd0, done}, 64'd1);
      repeat (3) @(negedge clk);
      chk("full", {63'd0, full}, {63'd0, st.size() == CAP});
      chk("sop_err", {63'd0, sop_err}, {63'd0, serr});
      chk("word_count", {53'd0, word_count}, 64'(nw));
      chk("sample_count", {51'd0, sample_count}, 64'(st.size()));
    end else begin
      repeat (3) @(negedge clk);
    end
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    frame.delete();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] word0;
    reset_n = 1'b0; arm = 1'b0; snk_valid = 1'b0; sop = 1'b0; eop = 1'b0; snk_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {snk_ready, address2, chipselect2, write2, byteenable2, done, full,
                       sop_err, word_count, sample_count}, '0);
    chk("reset_data", writedata2, '0);
    chk("reset_clken", {63'd0, clken2}, 64'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Eight-sample packet, two full words
    for (int i = 1; i <= 8; i++) add(16'(i), i == 1, i == 8);
    run_frame(1, 1, -1);

    // Six samples: second word is partial
    for (int i = 1; i <= 6; i++) add(16'hA000 + 16'(i), i == 1, i == 6);
    run_frame(1, 2, -1);

    // Leading junk without SOP is discarded
    for (int i = 0; i < 3; i++) add(16'($urandom), 0, 0);
    for (int i = 0; i < 4; i++) add(16'($urandom), i == 0, i == 3);
    run_frame(1, 1, -1);

    // Overlong packet at full rate: truncation then drain
    for (int i = 0; i < 4100; i++) add(16'($urandom), i == 0, i == 4099);
    run_frame(1, 0, -1);

    // Mid-frame SOP and an arm pulse that must be ignored
    for (int i = 0; i < 5; i++) add(16'($urandom), i == 0 || i == 2, i == 4);
    run_frame(1, 1, 3);

    // One-sample frame
    add(16'($urandom), 1, 1);
    run_frame(1, 0, -1);

    // Exactly full frame: EOP on the last slot goes straight to DONE
    for (int i = 0; i < CAP; i++) add(16'($urandom), i == 0, i == CAP - 1);
    run_frame(1, 0, -1);

    // Random frames
    for (int f = 0; f < 10; f++) begin
      int junk, len;
      junk = $urandom_range(0, 3);
      len  = $urandom_range(1, 13);
      for (int i = 0; i < junk; i++) add(16'($urandom), 0, 0);
      for (int i = 0; i < len; i++)
        add(16'($urandom), (i == 0) || ($urandom_range(0, 7) == 0), i == len - 1);
      run_frame(1, 2, -1);
    end

    // Reset mid-frame: first word stays in RAM, loader goes idle
    for (int i = 1; i <= 6; i++) add(16'h0100 + 16'(i), i == 1, 0);
    word0 = {16'h0104, 16'h0103, 16'h0102, 16'h0101};
    run_frame(0, 0, -1);
    @(negedge clk); reset_n = 1'b0;
    #1;
    chk("midreset_ctrl", {snk_ready, address2, chipselect2, write2, byteenable2, done, full,
                          sop_err, word_count, sample_count}, '0);
    chk("midreset_data", writedata2, '0);
    @(negedge clk); reset_n = 1'b1;
    snk_valid = 1'b1; snk_data = 16'h5555; sop = 1'b1; eop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ready_low_after_reset", {63'd0, snk_ready}, 64'd0);
    end
    snk_valid = 1'b0; sop = 1'b0; eop = 1'b0;
    chk("ram_word0_retained", mem[0], word0);
    chk("no_pending_writes", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
